// File: rtl/iwrr_pkg.sv
// Shared definitions for the IWRR arbiter: FSM encoding, a clog2 helper and
// the weight-field slice used wherever packed weight vectors are unpacked.
`ifndef IWRR_PKG_SV
`define IWRR_PKG_SV
`define IWRR_WFIELD(vec, idx, w) vec[(idx)*(w) +: (w)]

package iwrr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } iwrr_state_e;

  // Never returns less than 1 so that index registers stay at least one bit wide.
  function automatic int iwrr_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage
`endif

// File: rtl/iwrr_grant_scheduler_rr_priority_picker.sv
// Combinational rotating-priority picker: one-hot of the first set bit of
// i_elig found scanning i_ptr+1, i_ptr+2, ... modulo P_N.
module rr_priority_picker #(
  parameter int P_N     = 3,
  parameter int P_PTR_W = 2
) (
  input  logic [P_N-1:0]     i_elig,
  input  logic [P_PTR_W-1:0] i_ptr,
  output logic [P_N-1:0]     o_onehot,
  output logic               o_any
);

  int w_idx;

  always_comb begin
    o_onehot = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= P_N; k++) begin
      w_idx = (int'(i_ptr) + k) % P_N;
      if (!o_any && i_elig[w_idx]) begin
        o_onehot[w_idx] = 1'b1;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iwrr_grant_scheduler.sv
// Sequential core of the IWRR arbiter: round tracking, rotating-priority
// selection and a registered grant held under a valid/ready handshake.
module iwrr_grant_scheduler
  import iwrr_pkg::*;
#(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [P_REQUESTER_NUM-1:0]            req_i,
  input  logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] weight_i,
  input  logic                                  grant_ready_i,
  input  logic                                  round_comp_i,
  output logic                                  grant_valid_o,
  output logic [P_REQUESTER_NUM-1:0]            grant_o,
  output logic [P_WEIGHT_W-1:0]                 num_grant_req_o,
  output logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_weight_o
);

  localparam int N     = P_REQUESTER_NUM;
  localparam int W     = P_WEIGHT_W;
  localparam int PTR_W = iwrr_clog2(N);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

  iwrr_state_e      r_state, w_state_nxt;
  logic             r_valid;
  logic [N-1:0]     r_grant;
  logic [W-1:0]     r_rnd;
  logic [PTR_W-1:0] r_ptr;

  logic [N-1:0]     w_elig, w_sel_oh, w_nxt_oh, w_le_mask;
  logic             w_sel_any, w_nxt_any, w_hs, w_wrap, w_rnd_last;
  logic [W-1:0]     w_wt, w_max_w;
  logic [PTR_W-1:0] w_g;

  always_comb begin
    req_weight_o = '0;
    w_elig       = '0;
    w_max_w      = '0;
    w_wt         = '0;
    for (int i = 0; i < N; i++) begin
      w_wt = `IWRR_WFIELD(weight_i, i, W);
      `IWRR_WFIELD(req_weight_o, i, W) = req_i[i] ? w_wt : '0;
      w_elig[i] = req_i[i] && (w_wt > r_rnd);
      if (req_i[i] && (w_wt > w_max_w)) w_max_w = w_wt;
    end
  end

  always_comb begin
    w_g       = '0;
    w_le_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) w_g = PTR_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      w_le_mask[i] = (i <= int'(w_g));
    end
  end

  rr_priority_picker #(.P_N(N), .P_PTR_W(PTR_W)) u_sel_picker (
    .i_elig   (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_sel_oh),
    .o_any    (w_sel_any)
  );

  // Scanning from the granted index: a hit at or below g means the scan
  // wrapped, i.e. nothing above g is still eligible in this round.
  rr_priority_picker #(.P_N(N), .P_PTR_W(PTR_W)) u_nxt_picker (
    .i_elig   (w_elig),
    .i_ptr    (w_g),
    .o_onehot (w_nxt_oh),
    .o_any    (w_nxt_any)
  );

  assign w_hs       = (r_state == ST_GRANT) && r_valid && grant_ready_i;
  assign w_wrap     = !w_nxt_any || |(w_nxt_oh & w_le_mask);
  assign w_rnd_last = ({1'b0, r_rnd} + (W + 1)'(1)) >= {1'b0, w_max_w};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_sel_any) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_hs)      w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_grant <= '0;
      r_rnd   <= '0;
      r_ptr   <= PTR_LAST;
    end else if (r_state == ST_IDLE) begin
      if (w_sel_any) begin
        r_grant <= w_sel_oh;
        r_valid <= 1'b1;
      end else if (|req_i) begin
        r_rnd <= '0;
        r_ptr <= PTR_LAST;
      end
    end else if (w_hs) begin
      r_valid <= 1'b0;
      r_grant <= '0;
      if (round_comp_i) begin
        r_rnd <= '0;
        r_ptr <= PTR_LAST;
      end else if (w_wrap) begin
        r_rnd <= w_rnd_last ? '0 : r_rnd + W'(1);
        r_ptr <= PTR_LAST;
      end else begin
        r_ptr <= w_g;
      end
    end
  end

  assign grant_valid_o   = r_valid;
  assign grant_o         = r_grant;
  assign num_grant_req_o = r_rnd;

endmodule

// File: tb/tb_iwrr_grant_scheduler.sv
// Bench for iwrr_grant_scheduler: directed vector table, hand-written corner
// sequences, and randomized traffic against a round-based reference model.
module tb_iwrr_grant_scheduler;

  localparam int N = 3;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [0:N*W-1] weight_i = '0;
  logic           grant_ready_i = 1'b0;
  logic           round_comp_i = 1'b0;
  logic           grant_valid_o;
  logic [N-1:0]   grant_o;
  logic [W-1:0]   num_grant_req_o;
  logic [0:N*W-1] req_weight_o;

  int n_checks = 0;
  int n_fail   = 0;

  iwrr_grant_scheduler #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .weight_i        (weight_i),
    .grant_ready_i   (grant_ready_i),
    .round_comp_i    (round_comp_i),
    .grant_valid_o   (grant_valid_o),
    .grant_o         (grant_o),
    .num_grant_req_o (num_grant_req_o),
    .req_weight_o    (req_weight_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rst;
    logic [2:0] req;
    int         w0, w1, w2;
    bit         rdy, comp;
    bit         egv;
    logic [2:0] egr;
    int         ernd;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: a grant is either outstanding (busy, index g) or not.
  int wv[N];
  bit m_busy;
  int m_g, m_rnd, m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int a, input int b, input int c);
    wv[0] = a; wv[1] = b; wv[2] = c;
    for (int i = 0; i < N; i++) weight_i[i*W +: W] = W'(wv[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = '0; grant_ready_i = 1'b0; round_comp_i = 1'b0;
    m_busy = 0; m_g = 0; m_rnd = 0; m_ptr = N - 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [0:N*W-1] exp_req_weight();
    logic [0:N*W-1] e;
    e = '0;
    for (int i = 0; i < N; i++) if (req_i[i]) e[i*W +: W] = W'(wv[i]);
    return e;
  endfunction

  // One clock of the arbiter's rules, evaluated on the inputs currently driven.
  task automatic model_step();
    int max_w;
    bit more;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!m_busy && req_i[c] && wv[c] > m_rnd) begin
          m_busy = 1; m_g = c;
        end
      end
      if (!m_busy && req_i != 0) begin
        m_rnd = 0; m_ptr = N - 1;
      end
    end else if (grant_ready_i) begin
      m_busy = 0;
      m_ptr  = m_g;
      if (round_comp_i) begin
        m_rnd = 0; m_ptr = N - 1;
      end else begin
        more = 0;
        max_w = 0;
        for (int j = 0; j < N; j++) begin
          if (j > m_g && req_i[j] && wv[j] > m_rnd) more = 1;
          if (req_i[j] && wv[j] > max_w) max_w = wv[j];
        end
        if (!more) begin
          m_rnd = (m_rnd + 1 >= max_w) ? 0 : m_rnd + 1;
          m_ptr = N - 1;
        end
      end
    end
  endtask

  initial begin
    logic [0:N*W-1] e_rw;

    // Round sequence with weights {2,1,3}
    tbl.push_back('{1, 3'b111, 2, 1, 3, 1, 0, 1, 3'b001, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b010, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b100, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 1});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b001, 1});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 1});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b100, 1});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 2});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b100, 2});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b001, 0});
    // Single requester, weight 3: rounds 0,1,2,0
    tbl.push_back('{1, 3'b001, 3, 2, 1, 1, 0, 1, 3'b001, 0});
    tbl.push_back('{0, 3'b001, 3, 2, 1, 1, 0, 0, 3'b000, 1});
    tbl.push_back('{0, 3'b001, 3, 2, 1, 1, 0, 1, 3'b001, 1});
    tbl.push_back('{0, 3'b001, 3, 2, 1, 1, 0, 0, 3'b000, 2});
    tbl.push_back('{0, 3'b001, 3, 2, 1, 1, 0, 1, 3'b001, 2});
    tbl.push_back('{0, 3'b001, 3, 2, 1, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b001, 3, 2, 1, 1, 0, 1, 3'b001, 0});
    // Zero weight never granted
    tbl.push_back('{1, 3'b111, 1, 0, 1, 1, 0, 1, 3'b001, 0});
    tbl.push_back('{0, 3'b111, 1, 0, 1, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 1, 0, 1, 1, 0, 1, 3'b100, 0});
    tbl.push_back('{0, 3'b111, 1, 0, 1, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 1, 0, 1, 1, 0, 1, 3'b001, 0});
    tbl.push_back('{0, 3'b111, 1, 0, 1, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 1, 0, 1, 1, 0, 1, 3'b100, 0});
    // Round-complete forced at the round-1 handshake
    tbl.push_back('{1, 3'b111, 2, 1, 3, 1, 0, 1, 3'b001, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b010, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b100, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 1});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b001, 1});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 1, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b001, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 0, 3'b000, 0});
    tbl.push_back('{0, 3'b111, 2, 1, 3, 1, 0, 1, 3'b010, 0});

    do_reset();
    chk("reset_valid", 32'(grant_valid_o), 32'd0);
    chk("reset_grant", 32'(grant_o), 32'd0);
    chk("reset_rnd", 32'(num_grant_req_o), 32'd0);

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      req_i         = tbl[k].req;
      set_w(tbl[k].w0, tbl[k].w1, tbl[k].w2);
      grant_ready_i = tbl[k].rdy;
      round_comp_i  = tbl[k].comp;
      tick();
      chk($sformatf("vec%0d_valid", k), 32'(grant_valid_o), 32'(tbl[k].egv));
      chk($sformatf("vec%0d_grant", k), 32'(grant_o), 32'(tbl[k].egr));
      chk($sformatf("vec%0d_rnd", k), 32'(num_grant_req_o), 32'(tbl[k].ernd));
    end

    // Request masking of the weight vector
    req_i = 3'b001;
    set_w(3, 2, 1);
    #1;
    e_rw = '0;
    e_rw[0 +: W] = 2'd3;
    chk("req_weight_mask", 32'(req_weight_o), 32'(e_rw));

    // Grant held while not ready, even after requests drop
    do_reset();
    set_w(2, 1, 3);
    req_i = 3'b111;
    grant_ready_i = 1'b0;
    tick();
    chk("hold_first_valid", 32'(grant_valid_o), 32'd1);
    chk("hold_first_grant", 32'(grant_o), 32'b001);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req_i = 3'b000;
      tick();
      chk($sformatf("hold%0d_valid", c), 32'(grant_valid_o), 32'd1);
      chk($sformatf("hold%0d_grant", c), 32'(grant_o), 32'b001);
    end
    grant_ready_i = 1'b1;
    tick();
    chk("hold_release_valid", 32'(grant_valid_o), 32'd0);
    chk("hold_release_grant", 32'(grant_o), 32'd0);

    // Asynchronous reset while a grant is outstanding at round 1
    do_reset();
    set_w(2, 1, 3);
    req_i = 3'b111;
    grant_ready_i = 1'b1;
    repeat (7) tick();
    chk("pre_rst_grant", 32'(grant_o), 32'b001);
    chk("pre_rst_rnd", 32'(num_grant_req_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(grant_valid_o), 32'd0);
    chk("async_rst_grant", 32'(grant_o), 32'd0);
    chk("async_rst_rnd", 32'(num_grant_req_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_grant", 32'(grant_o), 32'b001);
    chk("post_rst_valid", 32'(grant_valid_o), 32'd1);

    // Randomized traffic against the reference model
    do_reset();
    set_w($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0)
        set_w($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      req_i         = N'($urandom_range(0, 7));
      grant_ready_i = ($urandom_range(0, 3) != 0);
      round_comp_i  = ($urandom_range(0, 9) == 0);
      #1;
      chk($sformatf("rnd%0d_req_weight", c), 32'(req_weight_o), 32'(exp_req_weight()));
      model_step();
      tick();
      chk($sformatf("rnd%0d_valid", c), 32'(grant_valid_o), 32'(m_busy));
      chk($sformatf("rnd%0d_grant", c), 32'(grant_o), m_busy ? (32'd1 << m_g) : 32'd0);
      chk($sformatf("rnd%0d_rnd", c), 32'(num_grant_req_o), 32'(m_rnd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iwrr_grant_scheduler.md
Name: iwrr_grant_scheduler

Overview:
Sequential core of the interleaved weighted round-robin (IWRR) arbiter. It tracks the current round, picks the next eligible requester with rotating priority, and holds the grant under a valid/ready handshake. It drives the round-completion detector with grant, round index and request-masked weights, and consumes the detector's round-complete flag to restart the round sequence.

Parameters:
P_REQUESTER_NUM, 3, number of requesters
P_WEIGHT_W, 2, weight width; max weight 2^P_WEIGHT_W-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  P_REQUESTER_NUM  request vector, bit i = requester i
weight_i  input  P_REQUESTER_NUM*P_WEIGHT_W  static weight config; packed [0:N*W-1], requester i at bits [i*W +: W]
grant_ready_i  input  1  consumer accepts the current grant
round_comp_i  input  1  round complete, from the detector
grant_valid_o  output  1  grant_o is valid
grant_o  output  P_REQUESTER_NUM  one-hot grant, registered
num_grant_req_o  output  P_WEIGHT_W  current round index, registered
req_weight_o  output  P_REQUESTER_NUM*P_WEIGHT_W  weight_i with each field zeroed where req_i bit is 0; combinational; same packing as weight_i

Behaviour:
- Reset (async, rst_n=0): state IDLE, grant_valid_o=0, grant_o=0, rnd=0 (num_grant_req_o=0), ptr=N-1.
- Eligibility: elig[i] = req_i[i] & (weight[i] > rnd). Weight 0 is never eligible.
- Selection: the first set elig index scanning ptr+1, ptr+2, … modulo N.
- IDLE:
  - any elig: register the selected one-hot into grant_o, set grant_valid_o=1, go to GRANT. Latency is 1 cycle from the req_i edge to grant_valid_o.
  - |req_i but no elig: rnd<=0, ptr<=N-1, stay IDLE. This is a one-cycle bubble.
  - no req: hold.
- GRANT:
  - grant_o and grant_valid_o held stable while grant_ready_i=0. No retraction, even if req_i drops.
  - Handshake (grant_valid_o & grant_ready_i), with g = granted index: ptr<=g; grant_valid_o<=0; grant_o<=0; go to IDLE. Sustained throughput is one grant per 2 cycles.
  - Round update on handshake, in priority order:
    1. round_comp_i=1: rnd<=0, ptr<=N-1.
    2. No elig[j] with j>g at current rnd: round wraps. rnd<=rnd+1, or rnd<=0 if rnd+1 >= max over requesting i of weight[i]; ptr<=N-1 in both cases.
    3. Otherwise: rnd unchanged.
- rnd never exceeds 2^W-2, so the W-bit field never overflows.
- round_comp_i is ignored when there is no handshake.
- Reset mid-GRANT drops the grant immediately.

Decomposition:
- Package iwrr_pkg: state encoding (IDLE, GRANT), a clog2 helper function, and the weight-field slice macro/function used by both this block and the detector.
- One sub-module, rr_priority_picker: combinational rotating-priority one-hot picker with inputs elig and ptr, outputs one-hot and any_found. The same picker is reused for the "elig above g" check with ptr=g.

Test Plan:
1. N=3, W=2, weights {2,1,3}, req=3'b111, ready=1 -> grant order 0,1,2 (rnd 0), 0,2 (rnd 1), 2 (rnd 2), then 0 with rnd=0; each grant_valid_o pulse separated by one idle cycle.
2. Same config, ready held 0 for 5 cycles after the first grant -> grant_o=3'b001 and grant_valid_o=1 stable all 5 cycles; req_i dropped to 0 meanwhile does not clear the grant.
3. Only req0 active, weight0=3 -> grants req0 with num_grant_req_o 0,1,2,0,…; req_weight_o = {3,0,0}.
4. weight1=0, req=3'b111, weights {1,0,1} -> requester 1 never granted; sequence 0,2,0,2 with rnd always 0.
5. Force round_comp_i=1 on the handshake at rnd=1 -> next num_grant_req_o=0 and the next grant goes to the lowest eligible index.
6. rst_n low for one cycle while in GRANT -> grant_valid_o=0, grant_o=0, num_grant_req_o=0 asynchronously; after release, the first grant goes to requester 0.
